// File: rtl/i2c_arbiter.sv
// i2c_arbiter: round-robin sharing of one I2C byte master between two requesters
module i2c_arbiter #(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 4096,
  parameter int CNT_W   = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r0_rw,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ack,
  output logic              r0_done,
  output logic [DATA_W-1:0] r0_rdata,
  output logic [1:0]        r0_err,
  input  logic              r1_req,
  input  logic              r1_rw,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ack,
  output logic              r1_done,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [1:0]        r1_err,
  output logic              m_start,
  output logic              m_rw,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_abort,
  input  logic              m_busy,
  input  logic              m_done,
  input  logic              m_nack,
  input  logic [DATA_W-1:0] m_rdata
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_d;
  logic gnt, last;
  logic [CNT_W-1:0] cnt;
  logic grant, pick1, issue, tmo, fin;
  logic [DATA_W-1:0] rd_d;
  logic [1:0] err_d;
  always_comb begin
    grant = state == IDLE && (r0_req || r1_req);
    pick1 = r1_req && (!r0_req || !last);
    issue = state == ISSUE && !m_busy;
    tmo = state == WAIT && !m_done && cnt == CNT_W'(TIMEOUT - 1);
    fin = (state == WAIT && m_done) || tmo;
    rd_d = m_done ? m_rdata : '0;
    err_d = m_done ? {1'b0, m_nack} : 2'b10;
    state_d = grant ? ISSUE : issue ? WAIT : fin ? RESP : state == RESP ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      gnt <= 1'b0;
      last <= 1'b1;
      cnt <= '0;
      {r0_ack, r1_ack, r0_done, r1_done, m_start, m_abort, m_rw} <= '0;
      m_addr <= '0;
      m_wdata <= '0;
      r0_rdata <= '0;
      r1_rdata <= '0;
      r0_err <= '0;
      r1_err <= '0;
    end else begin
      state <= state_d;
      r0_ack <= grant && !pick1;
      r1_ack <= grant && pick1;
      m_start <= issue;
      m_abort <= tmo;
      r0_done <= fin && !gnt;
      r1_done <= fin && gnt;
      cnt <= issue ? '0 : state == WAIT ? cnt + CNT_W'(1) : cnt;
      if (grant) begin
        gnt <= pick1;
        m_rw <= pick1 ? r1_rw : r0_rw;
        m_addr <= pick1 ? r1_addr : r0_addr;
        m_wdata <= pick1 ? r1_wdata : r0_wdata;
      end
      if (fin && !gnt) begin
        r0_rdata <= rd_d;
        r0_err <= err_d;
      end
      if (fin && gnt) begin
        r1_rdata <= rd_d;
        r1_err <= err_d;
      end
      if (state == RESP) last <= gnt;
    end
  end
endmodule

// File: tb/tb_i2c_arbiter.sv
// tb_i2c_arbiter: directed and randomized checks of i2c_arbiter against a timestamp-based model
module tb_i2c_arbiter;
  localparam int TIMEOUT = 16;
  logic clk = 0, rst = 0;
  logic [1:0] req = 0, rw = 0, ack, done;
  logic [6:0] addr [2];
  logic [7:0] wdata [2], rdata [2];
  logic [1:0] err [2];
  logic m_start, m_rw, m_abort, m_busy = 0, m_done = 0, m_nack = 0;
  logic [6:0] m_addr;
  logic [7:0] m_wdata, m_rdata = 0;
  int chk_cnt = 0, pass_cnt = 0, mmode = 0, rmode = 0, k = 0;
  logic [1:0] e_ack, e_done;
  logic e_start, e_abort, e_rw;
  logic [6:0] e_addr;
  logic [7:0] e_wdata, e_rdata [2];
  logic [1:0] e_err [2];
  int owner = -1, last = 1, start_cyc = 0, free_at = 0, n = 0;
  bit started = 0, seen = 0;

  i2c_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .r0_req(req[0]), .r0_rw(rw[0]), .r0_addr(addr[0]), .r0_wdata(wdata[0]),
    .r0_ack(ack[0]), .r0_done(done[0]), .r0_rdata(rdata[0]), .r0_err(err[0]),
    .r1_req(req[1]), .r1_rw(rw[1]), .r1_addr(addr[1]), .r1_wdata(wdata[1]),
    .r1_ack(ack[1]), .r1_done(done[1]), .r1_rdata(rdata[1]), .r1_err(err[1]),
    .m_start(m_start), .m_rw(m_rw), .m_addr(m_addr), .m_wdata(m_wdata), .m_abort(m_abort),
    .m_busy(m_busy), .m_done(m_done), .m_nack(m_nack), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    chk_cnt++;
    if (a === e) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, a, e, $time);
  endtask

  // Each transaction is tracked by its grant, start and deadline cycles.
  task automatic model();
    e_ack = 0; e_done = 0; e_start = 0; e_abort = 0;
    if (!rst) begin
      e_rw = 0; e_addr = 0; e_wdata = 0;
      e_rdata = '{8'h00, 8'h00}; e_err = '{2'b00, 2'b00};
      owner = -1; last = 1; free_at = n + 1;
    end else if (owner < 0) begin
      if (n >= free_at && req != 2'b00) begin
        owner = (req == 2'b11) ? 1 - last : (req[1] ? 1 : 0);
        e_rw = rw[owner]; e_addr = addr[owner]; e_wdata = wdata[owner];
        e_ack[owner] = 1'b1; started = 0;
      end
    end else if (!started) begin
      if (!m_busy) begin e_start = 1; start_cyc = n + 1; started = 1; end
    end else if (m_done || n - start_cyc == TIMEOUT - 1) begin
      e_rdata[owner] = m_done ? m_rdata : 8'h00;
      e_err[owner] = m_done ? {1'b0, m_nack} : 2'b10;
      e_abort = !m_done; e_done[owner] = 1'b1;
      last = owner; owner = -1; free_at = n + 2;
    end
    n++;
  endtask

  task automatic tick();
    @(posedge clk);
    model();
    @(negedge clk);
    if (mmode == 1) begin m_done = m_start; m_nack = 0; m_rdata = 8'h77; end
    else if (mmode == 2) begin
      m_done = $urandom_range(9) == 0; m_busy = $urandom_range(2) == 0;
      m_nack = 1'($urandom); m_rdata = 8'($urandom);
    end
    if (rmode != 0) begin
      for (int i = 0; i < 2; i++)
        if ((req[i] && ack[i]) || (!req[i] && $urandom_range(5) == 0)) begin
          req[i] = req[i] ? 1'($urandom) : 1'b1;
          rw[i] = 1'($urandom); addr[i] = 7'($urandom); wdata[i] = 8'($urandom);
        end
      rst = $urandom_range(499) != 0;
    end
  endtask

  function automatic logic sig(input int s);
    case (s)
      0: return ack[0];
      1: return ack[1];
      2: return done[0];
      3: return done[1];
      4: return m_start;
      5: return m_abort;
      6: return |ack;
      default: return |done;
    endcase
  endfunction

  task automatic wait_for(input int s, input string nm, output int cnt);
    cnt = 0;
    do begin tick(); cnt++; end while (!sig(s) && cnt < 200);
    if (!sig(s)) begin
      chk_cnt++;
      $display("FAIL %s: no event within %0d cycles", nm, cnt);
    end
  endtask

  always @(negedge clk) if (n > 0) begin
    chk("ack", 32'(ack), 32'(e_ack));
    chk("done", 32'(done), 32'(e_done));
    chk("start_abort", 32'({m_start, m_abort}), 32'({e_start, e_abort}));
    chk("m_fields", 32'({m_rw, m_addr, m_wdata}), 32'({e_rw, e_addr, e_wdata}));
    chk("r0_resp", 32'({rdata[0], err[0]}), 32'({e_rdata[0], e_err[0]}));
    chk("r1_resp", 32'({rdata[1], err[1]}), 32'({e_rdata[1], e_err[1]}));
  end

  initial begin
    addr = '{7'h00, 7'h00}; wdata = '{8'h00, 8'h00};
    tick(); tick();
    chk("reset_zero", 32'(|{ack, done, m_start, m_abort, m_rw, m_addr, m_wdata,
        rdata[0], err[0], rdata[1], err[1]}), 32'd0);
    rst = 1;
    // single write
    req[0] = 1; rw[0] = 0; addr[0] = 7'h48; wdata[0] = 8'hA5;
    wait_for(0, "wr_ack", k); chk("wr_ack_lat", 32'(k), 32'd1);
    req[0] = 0;
    wait_for(4, "wr_start", k); chk("wr_start_lat", 32'(k), 32'd1);
    chk("wr_fields", 32'({m_rw, m_addr, m_wdata}), 32'h48A5);
    m_done = 1;
    wait_for(2, "wr_done", k); m_done = 0;
    chk("wr_done_lat", 32'(k), 32'd1); chk("wr_err", 32'(err[0]), 32'd0);
    // read with NACK
    req[1] = 1; rw[1] = 1; addr[1] = 7'h50;
    wait_for(1, "rd_ack", k); req[1] = 0;
    wait_for(4, "rd_start", k);
    chk("rd_fields", 32'({m_rw, m_addr}), 32'hD0);
    m_done = 1; m_nack = 1; m_rdata = 8'h3C;
    wait_for(3, "rd_done", k); m_done = 0; m_nack = 0;
    chk("rd_resp", 32'({rdata[1], err[1]}), 32'h0F1);
    chk("r0_unchanged", 32'({rdata[0], err[0]}), 32'd0);
    // contention from reset
    rst = 0; req = 2'b11; rw = 2'b00; addr = '{7'h10, 7'h11};
    tick(); rst = 1; mmode = 1;
    for (int i = 0; i < 4; i++) begin
      wait_for(6, "ct_ack", k);
      chk("grant_order", 32'(ack[1]), 32'(i % 2));
    end
    req = 2'b00;
    wait_for(7, "ct_done", k); mmode = 0; m_done = 0;
    // busy hold longer than the timeout
    m_busy = 1; req[1] = 1;
    wait_for(1, "bz_ack", k); req[1] = 0; seen = 0;
    repeat (20) begin tick(); seen |= m_start | m_abort; end
    chk("busy_quiet", 32'(seen), 32'd0);
    m_busy = 0;
    wait_for(4, "bz_start", k); chk("busy_start_lat", 32'(k), 32'd1);
    m_done = 1; wait_for(3, "bz_done", k); m_done = 0;
    // timeout abort
    req[0] = 1; rw[0] = 1; addr[0] = 7'h20;
    wait_for(0, "to_ack", k); req[0] = 0;
    wait_for(4, "to_start", k);
    wait_for(5, "to_abort", k); chk("abort_dist", 32'(k), 32'd16);
    chk("to_done", 32'(done[0]), 32'd1);
    chk("to_resp", 32'({rdata[0], err[0]}), 32'h002);
    // done on the final cycle beats the timeout
    req[0] = 1;
    wait_for(0, "tb_ack", k); req[0] = 0;
    wait_for(4, "tb_start", k);
    repeat (15) tick();
    m_done = 1; m_rdata = 8'h5A;
    wait_for(2, "tb_done", k); m_done = 0;
    chk("late_done_lat", 32'(k), 32'd1); chk("late_no_abort", 32'(m_abort), 32'd0);
    chk("late_resp", 32'({rdata[0], err[0]}), 32'h168);
    // reset in the middle of WAIT
    req[1] = 1;
    wait_for(1, "rw_ack", k); req[1] = 0;
    wait_for(4, "rw_start", k);
    repeat (5) tick();
    rst = 0; tick(); rst = 1;
    chk("mid_reset_zero", 32'(|{ack, done, m_start, m_abort, m_rw, m_addr, m_wdata,
        rdata[0], err[0], rdata[1], err[1]}), 32'd0);
    seen = 0;
    repeat (20) begin tick(); seen |= |{done, m_abort}; end
    chk("mid_reset_silent", 32'(seen), 32'd0);
    req = 2'b11;
    wait_for(6, "pr_ack", k); chk("post_reset_tie", 32'(ack[0]), 32'd1);
    req = 2'b00; mmode = 1;
    wait_for(7, "pr_done", k);
    // randomized traffic
    rmode = 1; mmode = 2;
    repeat (4000) tick();
    rmode = 0; mmode = 0; rst = 1; req = 2'b00; m_done = 0; m_busy = 0;
    repeat (40) tick();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
